program_sequencer: RTL and testbench
====================================

PROGRAM_SEQUENCER -- requirements
Module: program_sequencer

Interface
REQ-001 SHALL have parameter PC_MAX, default 9, meaning the last valid ROM address; the program halts after issuing it.
REQ-002 SHALL have port clock  input  1  meaning the single system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  meaning asynchronous, active-low reset.
REQ-004 SHALL have port run_btn  input  1  meaning the run request, a debounced level.
REQ-005 SHALL have port step_btn  input  1  meaning the single-step/pause request, a debounced level.
REQ-006 SHALL have port mode_rom  input  1  meaning instruction source: 1=ROM, 0=switches.
REQ-007 SHALL have port switches  input  8  meaning the manually entered instruction.
REQ-008 SHALL have port rom_data  input  8  meaning combinational ROM output for rom_addr.
REQ-009 SHALL have port exec_ready  input  1  meaning the datapath accepts the issued instruction.
REQ-010 SHALL have port rom_addr  output  4  meaning the program counter, driven to the ROM.
REQ-011 SHALL have port instr  output  8  meaning the latched current instruction.
REQ-012 SHALL have port exec_valid  output  1  meaning instr is offered to the datapath.
REQ-013 SHALL have port halted  output  1  meaning the ROM program has completed.
REQ-014 SHALL have port retired  output  8  meaning the count of accepted instructions; wraps 255->0.

Function
REQ-015 SHALL edge-detect each button with a registered copy: edge = btn & ~btn_q; one edge per press.
REQ-016 SHALL implement states IDLE, FETCH, ISSUE, WAIT_STEP, HALT.
REQ-017 IDLE: pc=0. run edge -> FETCH with run_mode=1; else step edge -> FETCH with run_mode=0. Run wins on simultaneous edges.
REQ-018 SHALL latch mode_rom into src_rom on leaving IDLE and hold it until IDLE is re-entered; mode_rom changes mid-program are ignored.
REQ-019 FETCH (exactly 1 cycle): instr <= src_rom ? rom_data : switches; -> ISSUE.
REQ-020 ISSUE: exec_valid=1 with instr stable. Stays until exec_ready=1; the transfer occurs in the cycle where exec_valid & exec_ready.
REQ-021 On transfer: retired += 1. If src_rom and pc==PC_MAX -> HALT with pc held. Else pc += 1 (ROM source only; pc stays 0 for switches). Then -> FETCH if run_mode, else -> WAIT_STEP.
REQ-022 A step edge in FETCH or ISSUE SHALL clear run_mode (pause); the current instruction still completes.
REQ-023 WAIT_STEP: step edge -> FETCH with run_mode=0; run edge -> FETCH with run_mode=1; run wins on simultaneous edges.
REQ-024 HALT: halted=1, exec_valid=0. A step edge is ignored. A run edge -> IDLE with pc=0 and halted=0 (retired kept).
REQ-025 Latency: edge sampled in IDLE at clock edge k -> FETCH after k, ISSUE (exec_valid=1) after k+1.
REQ-026 exec_valid SHALL be 1 only in ISSUE and SHALL never drop before the transfer.
REQ-027 rom_addr SHALL equal pc at all times; pc SHALL never exceed PC_MAX.
REQ-028 Switch source never halts; run mode re-fetches switches every instruction.

Reset
REQ-029 reset=0 SHALL immediately force: state=IDLE, pc=0, instr=0x00, exec_valid=0, halted=0, retired=0, run_mode=0, src_rom=0, button registers=0.
REQ-030 Reset asserted mid-ISSUE SHALL drop exec_valid asynchronously; no transfer counts.
REQ-031 After reset release, a button held high across release SHALL NOT produce an edge until it returns low and rises again.

Verification
REQ-032 mode_rom=1, ROM[a]=0x10+a, run edge, exec_ready=1 -> instr 0x10..0x19 issued in order, each ISSUE one cycle, halted=1 after pc=9, retired=10.
REQ-033 mode_rom=1, step edge, exec_ready=1 -> one instr 0x10, state WAIT_STEP, rom_addr=1; second step edge -> 0x11 issued.
REQ-034 Run from ROM, exec_ready=0 for 5 cycles during the 3rd ISSUE -> exec_valid held, instr=0x12 stable, retired stays 2, then advances.
REQ-035 Run, step edge during the 4th ISSUE -> 4th completes, WAIT_STEP with rom_addr=4, retired=4.
REQ-036 mode_rom=0, switches=0xC7, step edge -> instr=0xC7, rom_addr=0, never halts; reset asserted during ISSUE -> all outputs zero at once.
REQ-037 In HALT: step edge -> no change; run edge -> IDLE with rom_addr=0, halted=0.

Source files
------------

// File: rtl/program_sequencer.sv
// program_sequencer: fetches instructions from a small ROM or from manual
// switches, offers each one to the datapath with a valid/ready handshake,
// and supports free-running, paused and single-step execution.
module program_sequencer #(
  parameter int unsigned PC_MAX = 9
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       run_btn,
  input  logic       step_btn,
  input  logic       mode_rom,
  input  logic [7:0] switches,
  input  logic [7:0] rom_data,
  input  logic       exec_ready,
  output logic [3:0] rom_addr,
  output logic [7:0] instr,
  output logic       exec_valid,
  output logic       halted,
  output logic [7:0] retired
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    ISSUE     = 3'd2,
    WAIT_STEP = 3'd3,
    HALT      = 3'd4
  } state_t;

  localparam logic [3:0] PC_LAST = 4'(PC_MAX);

  state_t     state_r, state_s;
  logic [3:0] pc_r, pc_s;
  logic [7:0] instr_r, instr_s;
  logic [7:0] retired_r, retired_s;
  logic       run_mode_r, run_mode_s;
  logic       src_rom_r, src_rom_s;
  logic       exec_valid_r, exec_valid_s;
  logic       halted_r, halted_s;
  logic       run_q_r, step_q_r;
  logic       run_arm_r, step_arm_r;
  logic       run_edge_s, step_edge_s, xfer_s;

  // A button only produces an edge once it has been seen low after reset,
  // so a button held across reset release stays silent until re-pressed.
  assign run_edge_s  = run_btn  & ~run_q_r  & run_arm_r;
  assign step_edge_s = step_btn & ~step_q_r & step_arm_r;
  assign xfer_s      = (state_r == ISSUE) & exec_ready;

  // State, datapath and registered-output storage.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r      <= IDLE;
      pc_r         <= 4'd0;
      instr_r      <= 8'h00;
      retired_r    <= 8'd0;
      run_mode_r   <= 1'b0;
      src_rom_r    <= 1'b0;
      exec_valid_r <= 1'b0;
      halted_r     <= 1'b0;
      run_q_r      <= 1'b0;
      step_q_r     <= 1'b0;
      run_arm_r    <= 1'b0;
      step_arm_r   <= 1'b0;
    end else begin
      state_r      <= state_s;
      pc_r         <= pc_s;
      instr_r      <= instr_s;
      retired_r    <= retired_s;
      run_mode_r   <= run_mode_s;
      src_rom_r    <= src_rom_s;
      exec_valid_r <= exec_valid_s;
      halted_r     <= halted_s;
      run_q_r      <= run_btn;
      step_q_r     <= step_btn;
      run_arm_r    <= run_arm_r  | ~run_btn;
      step_arm_r   <= step_arm_r | ~step_btn;
    end
  end

  // Next-state and datapath update logic.
  always_comb begin
    state_s    = state_r;
    pc_s       = pc_r;
    instr_s    = instr_r;
    retired_s  = retired_r;
    run_mode_s = run_mode_r;
    src_rom_s  = src_rom_r;
    case (state_r)
      IDLE: begin
        pc_s = 4'd0;
        if (run_edge_s) begin
          state_s    = FETCH;
          run_mode_s = 1'b1;
          src_rom_s  = mode_rom;
        end else if (step_edge_s) begin
          state_s    = FETCH;
          run_mode_s = 1'b0;
          src_rom_s  = mode_rom;
        end else begin
          state_s = IDLE;
        end
      end
      FETCH: begin
        instr_s = src_rom_r ? rom_data : switches;
        state_s = ISSUE;
        if (step_edge_s) begin
          run_mode_s = 1'b0;
        end else begin
          run_mode_s = run_mode_r;
        end
      end
      ISSUE: begin
        if (step_edge_s) begin
          run_mode_s = 1'b0;
        end else begin
          run_mode_s = run_mode_r;
        end
        if (xfer_s) begin
          retired_s = retired_r + 8'd1;
          if (src_rom_r && (pc_r == PC_LAST)) begin
            state_s = HALT;
          end else begin
            if (src_rom_r) begin
              pc_s = pc_r + 4'd1;
            end else begin
              pc_s = pc_r;
            end
            if (run_mode_s) begin
              state_s = FETCH;
            end else begin
              state_s = WAIT_STEP;
            end
          end
        end else begin
          state_s = ISSUE;
        end
      end
      WAIT_STEP: begin
        if (run_edge_s) begin
          state_s    = FETCH;
          run_mode_s = 1'b1;
        end else if (step_edge_s) begin
          state_s    = FETCH;
          run_mode_s = 1'b0;
        end else begin
          state_s = WAIT_STEP;
        end
      end
      HALT: begin
        if (run_edge_s) begin
          state_s = IDLE;
          pc_s    = 4'd0;
        end else begin
          state_s = HALT;
        end
      end
      default: begin
        state_s    = IDLE;
        pc_s       = 4'd0;
        run_mode_s = 1'b0;
      end
    endcase
  end

  // Output decode from the next state so outputs are registered alongside it.
  always_comb begin
    exec_valid_s = 1'b0;
    halted_s     = 1'b0;
    case (state_s)
      ISSUE:   exec_valid_s = 1'b1;
      HALT:    halted_s     = 1'b1;
      default: begin
        exec_valid_s = 1'b0;
        halted_s     = 1'b0;
      end
    endcase
  end

  assign rom_addr   = pc_r;
  assign instr      = instr_r;
  assign exec_valid = exec_valid_r;
  assign halted     = halted_r;
  assign retired    = retired_r;

endmodule

// File: tb/tb_program_sequencer.sv
// Directed testbench for program_sequencer: ROM run, single step, stall,
// pause, switch source, HALT behaviour and reset handling.
module tb_program_sequencer;

  logic       clock;
  logic       reset;
  logic       run_btn;
  logic       step_btn;
  logic       mode_rom;
  logic [7:0] switches;
  logic [7:0] rom_data;
  logic       exec_ready;
  logic [3:0] rom_addr;
  logic [7:0] instr;
  logic       exec_valid;
  logic       halted;
  logic [7:0] retired;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_sw;

  program_sequencer #(.PC_MAX(9)) dut (
    .clock      (clock),
    .reset      (reset),
    .run_btn    (run_btn),
    .step_btn   (step_btn),
    .mode_rom   (mode_rom),
    .switches   (switches),
    .rom_data   (rom_data),
    .exec_ready (exec_ready),
    .rom_addr   (rom_addr),
    .instr      (instr),
    .exec_valid (exec_valid),
    .halted     (halted),
    .retired    (retired)
  );

  // ROM image: ROM[a] = 0x10 + a
  assign rom_data = 8'h10 + {4'h0, rom_addr};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic press_run();
    run_btn = 1'b1;
    tick();
    run_btn = 1'b0;
  endtask

  task automatic press_step();
    step_btn = 1'b1;
    tick();
    step_btn = 1'b0;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    #2;
    reset = 1'b1;
    tick();
    tick();
  endtask

  initial begin
    reset      = 1'b0;
    run_btn    = 1'b0;
    step_btn   = 1'b0;
    mode_rom   = 1'b0;
    switches   = 8'h00;
    exec_ready = 1'b0;
    #3;
    check_eq("rst_addr",    32'(rom_addr),   32'd0);
    check_eq("rst_instr",   32'(instr),      32'h00);
    check_eq("rst_valid",   32'(exec_valid), 32'd0);
    check_eq("rst_halted",  32'(halted),     32'd0);
    check_eq("rst_retired", 32'(retired),    32'd0);
    reset = 1'b1;
    tick();
    tick();

    // Full ROM run
    mode_rom   = 1'b1;
    exec_ready = 1'b1;
    press_run();
    check_eq("run_fetch_valid", 32'(exec_valid), 32'd0);
    for (int a = 0; a < 10; a++) begin
      tick();
      check_eq("run_valid", 32'(exec_valid), 32'd1);
      check_eq("run_instr", 32'(instr),      32'(8'h10 + a));
      check_eq("run_addr",  32'(rom_addr),   32'(a));
      tick();
    end
    check_eq("halt_halted",  32'(halted),     32'd1);
    check_eq("halt_valid",   32'(exec_valid), 32'd0);
    check_eq("halt_retired", 32'(retired),    32'd10);
    check_eq("halt_addr",    32'(rom_addr),   32'd9);

    // HALT: step ignored, run returns to IDLE
    press_step();
    tick();
    check_eq("halt_step_halted", 32'(halted),   32'd1);
    check_eq("halt_step_addr",   32'(rom_addr), 32'd9);
    check_eq("halt_step_valid",  32'(exec_valid), 32'd0);
    press_run();
    check_eq("halt_run_halted",  32'(halted),   32'd0);
    check_eq("halt_run_addr",    32'(rom_addr), 32'd0);
    check_eq("halt_run_retired", 32'(retired),  32'd10);

    // Single step from ROM
    press_step();
    tick();
    check_eq("step1_valid", 32'(exec_valid), 32'd1);
    check_eq("step1_instr", 32'(instr),      32'h10);
    tick();
    check_eq("step1_wait_valid", 32'(exec_valid), 32'd0);
    check_eq("step1_wait_addr",  32'(rom_addr),   32'd1);
    check_eq("step1_retired",    32'(retired),    32'd11);
    tick();
    tick();
    check_eq("step1_hold_valid", 32'(exec_valid), 32'd0);
    press_step();
    tick();
    check_eq("step2_valid", 32'(exec_valid), 32'd1);
    check_eq("step2_instr", 32'(instr),      32'h11);
    check_eq("step2_addr",  32'(rom_addr),   32'd1);
    tick();
    check_eq("step2_wait_addr", 32'(rom_addr), 32'd2);
    check_eq("step2_retired",   32'(retired),  32'd12);

    // Stall during third ISSUE
    apply_reset();
    press_run();
    tick();
    tick();
    tick();
    tick();
    exec_ready = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      check_eq("stall_valid",   32'(exec_valid), 32'd1);
      check_eq("stall_instr",   32'(instr),      32'h12);
      check_eq("stall_retired", 32'(retired),    32'd2);
      tick();
    end
    check_eq("stall_end_valid", 32'(exec_valid), 32'd1);
    check_eq("stall_end_instr", 32'(instr),      32'h12);
    exec_ready = 1'b1;
    tick();
    check_eq("stall_done_retired", 32'(retired),    32'd3);
    check_eq("stall_done_addr",    32'(rom_addr),   32'd3);
    check_eq("stall_done_valid",   32'(exec_valid), 32'd0);

    // Pause with step during fourth ISSUE
    tick();
    check_eq("pause_instr", 32'(instr), 32'h13);
    step_btn = 1'b1;
    tick();
    step_btn = 1'b0;
    check_eq("pause_valid",   32'(exec_valid), 32'd0);
    check_eq("pause_addr",    32'(rom_addr),   32'd4);
    check_eq("pause_retired", 32'(retired),    32'd4);
    tick();
    check_eq("pause_hold_valid", 32'(exec_valid), 32'd0);
    check_eq("pause_hold_addr",  32'(rom_addr),   32'd4);

    // Switch source
    apply_reset();
    mode_rom = 1'b0;
    switches = 8'hC7;
    press_step();
    tick();
    check_eq("sw_instr", 32'(instr),    32'hC7);
    check_eq("sw_addr",  32'(rom_addr), 32'd0);
    tick();
    check_eq("sw_wait_addr",    32'(rom_addr), 32'd0);
    check_eq("sw_wait_retired", 32'(retired),  32'd1);
    press_run();
    exp_sw = 8'hC7;
    for (int i = 0; i < 12; i++) begin
      if (i == 3) mode_rom = 1'b1;
      if (i == 6) begin
        switches = 8'h5A;
        exp_sw   = 8'h5A;
      end
      tick();
      check_eq("swrun_instr",  32'(instr),    32'(exp_sw));
      check_eq("swrun_addr",   32'(rom_addr), 32'd0);
      check_eq("swrun_halted", 32'(halted),   32'd0);
      tick();
    end
    check_eq("swrun_retired", 32'(retired), 32'd13);

    // Reset mid-ISSUE, button held across release
    exec_ready = 1'b0;
    tick();
    check_eq("pre_rst_valid", 32'(exec_valid), 32'd1);
    run_btn = 1'b1;
    reset   = 1'b0;
    #1;
    check_eq("arst_valid",   32'(exec_valid), 32'd0);
    check_eq("arst_instr",   32'(instr),      32'h00);
    check_eq("arst_retired", 32'(retired),    32'd0);
    check_eq("arst_halted",  32'(halted),     32'd0);
    check_eq("arst_addr",    32'(rom_addr),   32'd0);
    #1;
    reset = 1'b1;
    tick();
    tick();
    tick();
    check_eq("held_btn_valid", 32'(exec_valid), 32'd0);
    run_btn = 1'b0;
    tick();
    run_btn = 1'b1;
    tick();
    run_btn = 1'b0;
    tick();
    check_eq("repress_valid", 32'(exec_valid), 32'd1);
    check_eq("repress_instr", 32'(instr),      32'h10);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
